video_mode_ctl: RTL and testbench

- Frame-synchronous display-mode controller in the sys_clk domain, placed between the user button and video_gen.
- Debounces the active-low push button and turns each accepted press into a toggle request for the colour/greyscale mode.
- Commits the requested mode to video_gen only at a frame boundary, so no frame is ever rendered in mixed mode.
- Also drives status LEDs and a switch counter for debug.

---
 rtl/video_mode_ctl.sv | 121 ++++++++++++
 tb/tb_video_mode_ctl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/video_mode_ctl.sv
// Debounced button to frame-synchronous colour/greyscale mode switch.
// Requests toggle a target mode; video_gen sees it only at frame start.
module video_mode_ctl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_n_i,
  input  logic       frame_start_i,
  output logic       grey_en_o,
  output logic       pending_o,
  output logic [7:0] switch_cnt_o,
  output logic [3:0] led_o
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q, sync2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             target_q, target_d;
  logic             grey_q, grey_d;
  logic             pending_q, pending_d;
  logic [7:0]       sw_cnt_q, sw_cnt_d;
  logic             btn_s;
  logic             press_acc;

  assign btn_s = sync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_acc = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!btn_s) state_d = PRESS_DB;
      end
      PRESS_DB: begin
        if (btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = HELD;
          cnt_d     = '0;
          press_acc = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        cnt_d = '0;
        if (btn_s) state_d = REL_DB;
      end
      REL_DB: begin
        if (!btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Commit samples the pre-toggle target, so a coincident press stays pending.
  always_comb begin
    target_d  = target_q ^ press_acc;
    pending_d = target_q ^ grey_q;
    grey_d    = grey_q;
    sw_cnt_d  = sw_cnt_q;
    if (frame_start_i) begin
      grey_d = target_q;
      if (target_q != grey_q) sw_cnt_d = sw_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      target_q  <= 1'b0;
      grey_q    <= 1'b0;
      pending_q <= 1'b0;
      sw_cnt_q  <= 8'd0;
    end else begin
      sync1_q   <= btn_n_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      grey_q    <= grey_d;
      pending_q <= pending_d;
      sw_cnt_q  <= sw_cnt_d;
    end
  end

  assign grey_en_o    = grey_q;
  assign pending_o    = pending_q;
  assign switch_cnt_o = sw_cnt_q;
  assign led_o        = {grey_q, pending_q, state_q == HELD, ~sync2_q};

endmodule

// File: tb/tb_video_mode_ctl.sv
// Bench for video_mode_ctl: directed scenarios plus random traffic,
// compared every cycle against a run-length debounce/commit model.
module tb_video_mode_ctl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_n = 1'b1;
  logic       fs = 1'b0;
  logic       grey_en;
  logic       pending;
  logic [7:0] sw_cnt;
  logic [3:0] led;

  int errors = 0;
  int checks = 0;

  bit auto_fs = 1'b1;
  int fcnt = 0;

  // model state
  bit m_s1, m_s2, m_lvl, m_tgt, m_grey, m_pend;
  int m_run, m_cnt;

  always #5 clk = ~clk;

  video_mode_ctl #(.DEBOUNCE_CYCLES(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .btn_n_i      (btn_n),
    .frame_start_i(fs),
    .grey_en_o    (grey_en),
    .pending_o    (pending),
    .switch_cnt_o (sw_cnt),
    .led_o        (led)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  // Press accepted after N+1 consecutive low samples seen while released;
  // release accepted after N+1 consecutive high samples while pressed.
  task automatic model_edge();
    bit samp, press, npend;
    if (rst) begin
      m_s1 = 1; m_s2 = 1; m_lvl = 1; m_run = 0;
      m_tgt = 0; m_grey = 0; m_pend = 0; m_cnt = 0;
      return;
    end
    samp = m_s2;
    m_s2 = m_s1;
    m_s1 = btn_n;
    press = 0;
    if (samp == m_lvl) m_run = 0;
    else begin
      m_run++;
      if (m_run == N + 1) begin
        m_lvl = samp;
        m_run = 0;
        press = !samp;
      end
    end
    npend = m_tgt ^ m_grey;
    if (fs) begin
      if (m_tgt != m_grey) m_cnt = (m_cnt + 1) % 256;
      m_grey = m_tgt;
    end
    m_pend = npend;
    if (press) m_tgt = !m_tgt;
  endtask

  function automatic bit press_next();
    return !rst && m_s2 == 0 && m_lvl == 1 && m_run == N;
  endfunction

  task automatic step();
    if (auto_fs) fs = (fcnt == 99);
    @(posedge clk);
    model_edge();
    fcnt = (fcnt == 99) ? 0 : fcnt + 1;
    #1;
    check("grey", grey_en, m_grey);
    check("pend", pending, m_pend);
    check("swcnt", sw_cnt, m_cnt);
    check("led", led, {m_grey, m_pend, (m_lvl == 0 && m_run == 0), !m_s2});
  endtask

  task automatic run(input int n, input bit b);
    btn_n = b;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int guard;
    rst = 1; btn_n = 1;
    step(); step();
    rst = 0;
    check("rst_grey", grey_en, 0);
    check("rst_led", led, 0);
    run(300, 1);

    // single clean press, then wait past a frame
    run(20, 0);
    run(200, 1);

    // bounce shorter than debounce window
    for (int i = 0; i < 15; i++) run(4, i[0]);
    run(150, 1);

    // two presses inside one frame cancel
    fcnt = 0;
    run(20, 0); run(20, 1); run(20, 0); run(20, 1);
    run(150, 1);

    // press coincident with frame start
    auto_fs = 0;
    fs = 0;
    btn_n = 0;
    guard = 0;
    while (!press_next() && guard < 50) begin
      step();
      guard++;
    end
    check("coinc_found", guard < 50, 1);
    fs = 1;
    step();
    fs = 0;
    check("coinc_pend", pending, 0);
    step();
    check("coinc_pend2", pending, 1);
    run(20, 1);
    fs = 1; step(); fs = 0;
    run(5, 1);

    // reset while held with a request pending
    run(15, 0);
    check("held_pend", pending, 1);
    rst = 1; step(); rst = 0;
    check("rst_mid_led", led, 0);
    run(30, 0);
    run(20, 1);

    // 256 committed toggles wrap the switch counter
    for (int k = 0; k < 256; k++) begin
      run(12, 0);
      run(12, 1);
      fs = 1; step(); fs = 0;
    end
    check("wrap_cnt", sw_cnt, m_cnt);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) btn_n = !btn_n;
      fs = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
      rst = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
